// File: rtl/dmem_bus_bridge.sv
// Turns the single-cycle datapath's combinational load/store request into a valid/ready
// bus transaction and stalls the core until it completes. Optional macro: BUS_TIMEOUT_EN.
module dmem_bus_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_we,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [DATA_W-1:0] bus_req_wdata,
  input  logic              bus_resp_valid,
  input  logic [DATA_W-1:0] bus_resp_data,
  output logic              bus_resp_ready,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  localparam logic [DATA_W-1:0] TMO_DATA = DATA_W'(32'hDEADBEEF);

  state_t state, state_nxt;
  logic   mem_op;
  logic   tmo_abort;

  assign mem_op = memread | memwrite;
  assign stall  = mem_op && (state != DONE);

  // The bus only ever sees word addresses, so the byte offset is dropped.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^addr[1:0];

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

  logic [CNT_W-1:0] tmo_cnt;
  logic             busy;
  logic             tmo_hit;

  assign busy    = (state == REQ) || (state == RESP);
  assign tmo_hit = busy && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  // A response landing on the final allowed cycle still completes normally.
  assign tmo_abort = tmo_hit && !((state == RESP) && bus_resp_valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (busy) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign tmo_abort      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (mem_op) state_nxt = REQ;
      REQ: begin
        if (tmo_abort) begin
          state_nxt = DONE;
        end else if (bus_req_valid && bus_req_ready) begin
          state_nxt = RESP;
        end
      end
      RESP: if (bus_resp_valid || tmo_abort) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus-facing registers; CPU inputs are sampled only when a request starts in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_req_valid  <= 1'b0;
      bus_req_we     <= 1'b0;
      bus_req_addr   <= '0;
      bus_req_wdata  <= '0;
      bus_resp_ready <= 1'b0;
      rdata          <= '0;
      err            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            bus_req_addr  <= {addr[ADDR_W-1:2], 2'b00};
            bus_req_wdata <= wdata;
            bus_req_we    <= memwrite;
            bus_req_valid <= 1'b1;
          end
        end
        REQ: begin
          if (bus_req_ready) begin
            bus_req_valid  <= 1'b0;
            bus_resp_ready <= 1'b1;
          end
        end
        RESP: begin
          if (bus_resp_valid) begin
            bus_resp_ready <= 1'b0;
            if (!bus_req_we) rdata <= bus_resp_data;
          end
        end
        default: ;
      endcase
      if (tmo_abort) begin
        bus_req_valid  <= 1'b0;
        bus_resp_ready <= 1'b0;
        err            <= 1'b1;
        if (!bus_req_we) rdata <= TMO_DATA;
      end
    end
  end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Randomized bench for dmem_bus_bridge: a timeline model predicts every output per cycle
// from the access/response delays the bench itself chooses for the memory side.
module tb_dmem_bus_bridge;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread, memwrite;
  logic [31:0] addr, wdata, rdata;
  logic        stall;
  logic        bus_req_valid, bus_req_ready, bus_req_we;
  logic [31:0] bus_req_addr, bus_req_wdata;
  logic        bus_resp_valid;
  logic [31:0] bus_resp_data;
  logic        bus_resp_ready;
  logic        err;

  dmem_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_we(bus_req_we), .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata),
    .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data),
    .bus_resp_ready(bus_resp_ready), .err(err)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   stall_total = 0;
  bit   chk_en = 0;
  logic exp_stall, exp_valid, exp_rr, exp_we, exp_err;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Mid-cycle comparison of every output against the model's expectation for this cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("stall", stall, exp_stall);
      checkOutput("req_valid", bus_req_valid, exp_valid);
      checkOutput("resp_ready", bus_resp_ready, exp_rr);
      checkOutput("rdata", rdata, exp_rdata);
      checkOutput("err", err, exp_err);
      if (exp_valid) begin
        checkOutput("req_addr", bus_req_addr, exp_addr);
        checkOutput("req_we", bus_req_we, exp_we);
        checkOutput("req_wdata", bus_req_wdata, exp_wdata);
      end
      if (stall) stall_total++;
    end
  end

  function automatic logic rand1();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [31:0] wd, input logic rdy, input logic rv,
                               input logic [31:0] rsp);
    memread        = rd;
    memwrite       = wr;
    addr           = a;
    wdata          = wd;
    bus_req_ready  = rdy;
    bus_resp_valid = rv;
    bus_resp_data  = rsp;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    exp_stall = 1'b0;
    exp_valid = 1'b0;
    exp_rr    = 1'b0;
    applyStimulus(1'b0, 1'b0, $urandom, $urandom, rand1(), rand1(), $urandom);
  endtask

  // One access: the memory accepts after acc_wait refused cycles and answers resp_wait
  // cycles into the response phase (resp_wait<0: never; then hold response cycles run).
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rsp,
                         input int acc_wait, input int resp_wait, input int hold);
    int          resp_cycles;
    bit          timed_out;
    bit          completes;
    logic [31:0] got;
    timed_out   = 0;
    completes   = (resp_wait >= 0);
    resp_cycles = completes ? resp_wait + 1 : hold;
`ifdef BUS_TIMEOUT_EN
    if (!completes || (acc_wait + resp_wait + 2 > TMO)) begin
      if (completes || (hold >= TMO - acc_wait - 1)) begin
        timed_out   = 1;
        completes   = 1;
        resp_cycles = TMO - acc_wait - 1;
      end
    end
`endif
    got       = exp_rdata;
    exp_stall = 1'b1;
    exp_valid = 1'b0;
    exp_rr    = 1'b0;
    applyStimulus(rd, wr, a, wd, rand1(), rand1(), $urandom);
    exp_valid = 1'b1;
    exp_we    = wr;
    exp_addr  = {a[31:2], 2'b00};
    exp_wdata = wd;
    for (int k = 0; k <= acc_wait; k++)
      applyStimulus(rd, wr, $urandom, $urandom, (k == acc_wait), rand1(), $urandom);
    exp_valid = 1'b0;
    exp_rr    = 1'b1;
    for (int j = 0; j < resp_cycles; j++) begin
      if (j == resp_wait) begin
        applyStimulus(rd, wr, $urandom, $urandom, rand1(), 1'b1, rsp);
        got = rsp;
      end else begin
        applyStimulus(rd, wr, $urandom, $urandom, rand1(), 1'b0, $urandom);
      end
    end
    if (!completes) return;
    exp_rr    = 1'b0;
    exp_stall = 1'b0;
    if (timed_out) begin
      exp_err = 1'b1;
      if (!wr) got = 32'hDEADBEEF;
    end
    if (!wr) exp_rdata = got;
    applyStimulus(rd, wr, $urandom, $urandom, rand1(), rand1(), $urandom);
  endtask

  initial begin
    int s0;
    int op;
    logic rd, wr;
    reset = 1'b0;
    memread = 1'b0; memwrite = 1'b0; addr = '0; wdata = '0;
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_data = '0;
    #12;
    checkOutput("rst_valid", bus_req_valid, 0);
    checkOutput("rst_we", bus_req_we, 0);
    checkOutput("rst_addr", bus_req_addr, 0);
    checkOutput("rst_wdata", bus_req_wdata, 0);
    checkOutput("rst_resp_ready", bus_resp_ready, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_stall", stall, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_rdata = '0; exp_err = 1'b0; exp_stall = 1'b0; exp_valid = 1'b0;
    exp_rr = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
    chk_en = 1;
    idle_cycle();

    s0 = stall_total;
    run_txn(1'b1, 1'b0, 32'h13, 32'h0, 32'hCAFEF00D, 0, 0, 0);
    checkOutput("load_stall_cycles", stall_total - s0, 3);
    checkOutput("load_rdata", rdata, 32'hCAFEF00D);
    checkOutput("load_addr", bus_req_addr, 32'h10);
    checkOutput("load_we", bus_req_we, 0);

    run_txn(1'b0, 1'b1, 32'h40, 32'h12345678, $urandom, 4, 0, 0);
    checkOutput("store_rdata_kept", rdata, 32'hCAFEF00D);
    checkOutput("store_wdata", bus_req_wdata, 32'h12345678);
    checkOutput("store_addr", bus_req_addr, 32'h40);

    run_txn(1'b1, 1'b0, $urandom, $urandom, $urandom, 0, 0, 0);
    idle_cycle();
    run_txn(1'b0, 1'b1, $urandom, $urandom, $urandom, 0, 0, 0);
    run_txn(1'b1, 1'b0, $urandom, $urandom, $urandom, 0, 1, 0);

    run_txn(1'b1, 1'b1, 32'h87, 32'hA5A50F0F, 32'h11112222, 1, 1, 0);
    checkOutput("both_we", bus_req_we, 1);
    checkOutput("both_addr", bus_req_addr, 32'h84);

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      rd = (op != 1);
      wr = (op != 0);
      if ($urandom_range(0, 2) == 0) idle_cycle();
      run_txn(rd, wr, $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end

`ifdef BUS_TIMEOUT_EN
    run_txn(1'b1, 1'b0, 32'h200, 32'h0, 32'h0BADF00D, 0, TMO - 2, 0);
    checkOutput("edge_rdata", rdata, 32'h0BADF00D);
    checkOutput("edge_err", err, 0);
    run_txn(1'b1, 1'b0, 32'h204, 32'h0, 32'h0, 0, -1, 0);
    checkOutput("tmo_rdata", rdata, 32'hDEADBEEF);
    checkOutput("tmo_err", err, 1);
    run_txn(1'b0, 1'b1, $urandom, $urandom, $urandom, 1, 1, 0);
    run_txn(1'b1, 1'b0, $urandom, $urandom, $urandom, 0, 0, 0);
    checkOutput("err_sticky", err, 1);
    run_txn(1'b1, 1'b0, 32'h300, 32'h0, 32'h0, 0, -1, 2);
`else
    run_txn(1'b1, 1'b0, 32'h204, 32'h0, 32'h0, 0, -1, 20);
    checkOutput("hang_stall", stall, 1);
    checkOutput("hang_err", err, 0);
    checkOutput("hang_resp_ready", bus_resp_ready, 1);
`endif

    // Bridge is parked in the response phase here; drop reset between clock edges.
    chk_en = 0;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_resp_ready", bus_resp_ready, 0);
    checkOutput("async_valid", bus_req_valid, 0);
    checkOutput("async_rdata", rdata, 0);
    checkOutput("async_err", err, 0);
    exp_rdata = '0;
    exp_err   = 1'b0;
    @(posedge clk);
    #1;
    reset  = 1'b1;
    chk_en = 1;
    idle_cycle();
    run_txn(1'b1, 1'b0, 32'h500, 32'h0, 32'h5555AAAA, 0, 0, 0);
    checkOutput("post_rst_rdata", rdata, 32'h5555AAAA);
    idle_cycle();
    chk_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_bus_bridge.md
Name: dmem_bus_bridge

Overview:
Sits directly downstream of the single-cycle datapath's data-memory port. It converts the datapath's combinational memory request (address from aluout, writedata, memread/memwrite) into a valid/ready bus transaction towards an external data memory with variable latency. It returns the read data to the result mux and asserts stall, so the PC register and register file hold until the access completes.

Parameters:
ADDR_W, 32, byte-address width of the CPU and bus address
DATA_W, 32, data word width
TIMEOUT_CYCLES, 255, cycles allowed in REQ+RESP before abort; used only with BUS_TIMEOUT_EN

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately
memread  input  1  datapath requests a load this instruction
memwrite  input  1  datapath requests a store this instruction
addr  input  ADDR_W  byte address (datapath aluout)
wdata  input  DATA_W  store data (datapath writedata)
rdata  output  DATA_W  load data to the datapath result mux
stall  output  1  core must hold PC and suppress regwrite while 1
bus_req_valid  output  1  request valid
bus_req_ready  input  1  memory accepts the request
bus_req_we  output  1  1 = write, 0 = read
bus_req_addr  output  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
bus_req_wdata  output  DATA_W  write data
bus_resp_valid  input  1  response (read data or write ack) valid
bus_resp_data  input  DATA_W  read data
bus_resp_ready  output  1  bridge accepts the response
err  output  1  sticky bus-timeout flag

Behaviour:
- Reset (reset=0, async): state=IDLE; all registered outputs 0: bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_resp_ready, rdata, err. Any in-flight transaction is abandoned. The bus side must tolerate the drop.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - If memread|memwrite: latch addr (word-aligned), wdata and we=memwrite; go to REQ.
  - If both memread and memwrite are 1, treat as write (we=1).
  - Otherwise stay in IDLE.
- REQ:
  - bus_req_valid=1; addr, we and wdata are held stable until accepted.
  - On valid&&bus_req_ready: go to RESP; bus_req_valid drops the next cycle.
- RESP:
  - bus_resp_ready=1.
  - On bus_resp_valid: if read, rdata<=bus_resp_data; if write, rdata is unchanged. Go to DONE.
  - bus_resp_valid outside RESP is ignored (bus_resp_ready=0).
- DONE:
  - One cycle; stall=0 so the core commits on this edge.
  - Next state is IDLE unconditionally, so a back-to-back memory instruction starts in the following cycle.
- stall is combinational: stall = (memread|memwrite) && (state!=DONE). No stall for non-memory instructions, so zero-overhead ALU/branch instructions are preserved.
- Minimum memory-access latency with bus_req_ready=1 and response in the next cycle: IDLE→REQ→RESP→DONE, i.e. 3 stall cycles then commit.
- CPU inputs are ignored outside IDLE; the latched copies drive the bus.
- rdata holds its last value between loads.

Optional Feature:
Macro BUS_TIMEOUT_EN.
- Defined:
  - An 8..32-bit counter clears on entry to REQ and increments each cycle in REQ/RESP.
  - When it reaches TIMEOUT_CYCLES: drop bus_req_valid and bus_resp_ready, set rdata=32'hDEADBEEF for reads, set err=1 (sticky until reset), go to DONE.
  - A response arriving in the same cycle as the timeout wins; no error is raised.
- Undefined: no counter; the bridge waits indefinitely; err tied to 0.

Test Plan:
- Reset, then a load at addr=0x0000_0013 with ready=1 and resp 1 cycle later, data 0xCAFE_F00D → bus_req_addr=0x0000_0010, we=0; stall high for 3 cycles; rdata=0xCAFE_F00D in the DONE cycle.
- Store addr=0x40, wdata=0x1234_5678, bus_req_ready held 0 for 4 cycles → valid, addr and wdata stable all 4 cycles; the handshake occurs on the 5th; rdata unchanged.
- Back-to-back load then store, plus a non-memory instruction between them → stall=0 in DONE and for the non-memory cycle; the second transaction starts the cycle after DONE.
- memread=memwrite=1 → bus_req_we=1. Also drive spurious bus_resp_valid during IDLE/REQ → ignored; state and rdata unaffected.
- Assert reset=0 asynchronously mid-RESP → bus_resp_ready, bus_req_valid, rdata and err go to 0 without waiting for a clock edge; after release, state=IDLE.
- With BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, bus_resp_valid never asserted → DONE after 8 cycles in REQ/RESP, rdata=0xDEADBEEF, err=1 and stays 1 over later good transactions; without the macro, stall remains high.
